// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch requester for a word-addressed instruction memory. Presents the
//   fetch PC on imem_addr, captures the same-cycle imem_data and buffers
//   {pc, instr} pairs in a DEPTH-entry prefetch FIFO for the decode stage.
//   Handles branch redirects (flush + refetch) and end-of-program drain.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse, leaves IDLE
//   imem_addr/data   instruction memory address out, instruction in
//   redirect_valid/pc  flush request and new fetch PC
//   instr_valid/ready/instr/instr_pc  FIFO head handshake to decode
//   count            FIFO occupancy
//   done             program fully fetched and drained
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned MAX_ADDR = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [15:0]                  imem_addr,
    input  logic [31:0]                  imem_data,
    input  logic                         redirect_valid,
    input  logic [15:0]                  redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [31:0]                  instr,
    output logic [15:0]                  instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [16:0]   MAX_C   = 17'(MAX_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [16:0]   pc_q, pc_d;        // 17 bits so MAX_ADDR=65536 is reachable
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   mem_pc_q  [DEPTH];
    logic [31:0]   mem_ins_q [DEPTH];
    logic          push, pop;
    logic [16:0]   redir_pc17;

    assign instr_valid = (cnt_q != '0);
    // A handshake in a redirect cycle still counts as consumed.
    assign pop         = instr_valid & instr_ready;
    assign redir_pc17  = {1'b0, redirect_pc};

    assign imem_addr = pc_q[15:0];
    assign count     = cnt_q;
    assign instr     = instr_valid ? mem_ins_q[rd_q] : '0;
    assign instr_pc  = instr_valid ? mem_pc_q[rd_q]  : '0;
    assign done      = (state_q == S_DONE);

    always_comb begin
        push    = 1'b0;
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (redirect_valid) begin
            cnt_d = '0;
            // Out-of-range targets park fetch_pc at MAX_ADDR so it never exceeds it.
            pc_d  = (redir_pc17 < MAX_C) ? redir_pc17 : MAX_C;
            if (state_q != S_IDLE)
                state_d = (redir_pc17 < MAX_C) ? S_RUN : S_DONE;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_d = S_RUN;
                S_RUN: begin
                    if (pc_q < MAX_C) begin
                        push = (cnt_q != DEPTH_C) | pop;
                        if (push) begin
                            pc_d = pc_q + 17'd1;
                            if (pc_q == MAX_C - 17'd1) state_d = S_DRAIN;
                        end
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: if (cnt_q - CW'(pop) == '0) state_d = S_DONE;
                default: ;
            endcase
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= {1'b0, RESET_PC};
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            if (redirect_valid) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (pop)  rd_q <= rd_q + PW'(1);
                if (push) wr_q <= wr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_q]  <= pc_q[15:0];
            mem_ins_q[wr_q] <= imem_data;
        end
    end
endmodule
